// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial word shifter with one-entry holding register
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic [7:0]       frame_count
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [7:0]       r_frame_count;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_hold_next;
    logic             w_hold_full_next;
    logic [7:0]       w_frame_count_next;

    logic             w_accept;
    logic             w_shifting;
    logic             w_frame_end;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    // The output end of the shift register depends on bit order; shifting
    // always moves the next bit toward that end.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_out_bit = r_sreg[0];
        end
    endgenerate

    // Ready is purely a function of the holding register so upstream never
    // sees a combinational path from load_valid back to load_ready.
    assign load_ready  = ~r_hold_full;
    assign w_accept    = load_valid & ~r_hold_full;
    assign w_shifting  = (r_state == ST_SHIFT) & ser_en;
    assign w_frame_end = w_shifting & (r_cnt == CNT_LAST);

    assign ser_valid   = (r_state == ST_SHIFT);
    assign ser_out     = ser_valid & w_out_bit;
    assign ser_first   = ser_valid & (r_cnt == '0);
    assign ser_last    = ser_valid & (r_cnt == CNT_LAST);
    assign frame_count = r_frame_count;

    // State and datapath registers; reset clears any in-flight and held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sreg        <= '0;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_sreg        <= w_sreg_next;
            r_cnt         <= w_cnt_next;
            r_hold        <= w_hold_next;
            r_hold_full   <= w_hold_full_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    // Next-state logic: load from idle, shift, and chain the next frame at
    // end-of-frame (held word first, then a same-edge bypass, else idle).
    always_comb begin
        w_state_next       = r_state;
        w_sreg_next        = r_sreg;
        w_cnt_next         = r_cnt;
        w_hold_next        = r_hold;
        w_hold_full_next   = r_hold_full;
        w_frame_count_next = r_frame_count;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sreg_next  = load_data;
                    w_cnt_next   = '0;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_frame_end) begin
                    w_frame_count_next = r_frame_count + 8'd1;
                    if (r_hold_full) begin
                        // load_ready is low here, so no accept can collide
                        w_sreg_next      = r_hold;
                        w_cnt_next       = '0;
                        w_hold_full_next = 1'b0;
                    end else if (w_accept) begin
                        w_sreg_next = load_data;
                        w_cnt_next  = '0;
                    end else begin
                        w_sreg_next  = '0;
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    if (w_shifting) begin
                        w_sreg_next = w_shifted;
                        w_cnt_next  = r_cnt + CW'(1);
                    end
                    if (w_accept) begin
                        w_hold_next      = load_data;
                        w_hold_full_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       m_ready;
    logic       m_en = 1'b1;
    logic       m_out, m_sv, m_first, m_last;
    logic [7:0] m_fc;

    logic       l_valid = 1'b0;
    logic [7:0] l_data = 8'd0;
    logic       l_ready;
    logic       l_en = 1'b1;
    logic       l_out, l_sv, l_first, l_last;
    logic [7:0] l_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .load_valid(m_valid), .load_data(m_data),
        .load_ready(m_ready), .ser_en(m_en), .ser_out(m_out), .ser_valid(m_sv),
        .ser_first(m_first), .ser_last(m_last), .frame_count(m_fc)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .load_valid(l_valid), .load_data(l_data),
        .load_ready(l_ready), .ser_en(l_en), .ser_out(l_out), .ser_valid(l_sv),
        .ser_first(l_first), .ser_last(l_last), .frame_count(l_fc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected serial stream as a queue of bits
    typedef struct {
        logic b;
        logic f;
        logic l;
    } sbit_t;

    sbit_t q[$];
    int    model_fc = 0;
    logic  mon_rdy;

    function automatic logic exp_ready();
        int n = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i].f) n++;
        return (n == 0);
    endfunction

    task automatic push_word(input logic [7:0] w);
        sbit_t s;
        for (int i = 0; i < 8; i++) begin
            s.b = w[7 - i];
            s.f = (i == 0);
            s.l = (i == 7);
            q.push_back(s);
        end
    endtask

    // Monitor: compare MSB-first DUT against the queue each cycle
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            model_fc = 0;
        end else begin
            mon_rdy = exp_ready();
            check("frame_count", m_fc, 32'(model_fc % 256));
            check("load_ready", m_ready, mon_rdy);
            if (q.size() > 0) begin
                check("ser_valid", m_sv, 1);
                check("ser_out", m_out, q[0].b);
                check("ser_first", m_first, q[0].f);
                check("ser_last", m_last, q[0].l);
                if (m_en) begin
                    if (q[0].l) model_fc++;
                    void'(q.pop_front());
                end
            end else begin
                check("idle_valid", m_sv, 0);
                check("idle_out", m_out, 0);
                check("idle_first", m_first, 0);
                check("idle_last", m_last, 0);
            end
            if (m_valid && mon_rdy) push_word(m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_m(input logic [7:0] w);
        m_valid = 1'b1;
        m_data  = w;
        tick();
        m_valid = 1'b0;
        m_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_sv && k < 100) begin
            tick();
            k++;
        end
        check("drain_timeout", (k < 100), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cap, fm, lm, w;
        logic [15:0] cap16, vm16;
        logic        b;
        int          k;

        // Reset, then 0xA5 accepted on the first edge after release
        repeat (2) tick();
        reset = 1'b0;
        check("rst_ready", m_ready, 1);
        check("rst_valid", m_sv, 0);
        load_m(8'hA5);
        for (int i = 0; i < 8; i++) begin
            cap[7 - i] = m_out;
            fm[7 - i]  = m_first;
            lm[7 - i]  = m_last;
            tick();
        end
        check("a5_bits", cap, 8'hA5);
        check("a5_first", fm, 8'h80);
        check("a5_last", lm, 8'h01);
        check("a5_idle", m_sv, 0);
        check("a5_fc", m_fc, 1);

        // 0x0F then 0xF0 into the holding register: 16 contiguous bits
        m_valid = 1'b1;
        m_data  = 8'h0F;
        tick();
        cap16[15] = m_out;
        vm16[15]  = m_sv;
        check("hold_ready_c1", m_ready, 1);
        m_data = 8'hF0;
        tick();
        m_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            cap16[15 - i] = m_out;
            vm16[15 - i]  = m_sv;
            if (i <= 7) check("hold_ready_busy", m_ready, 0);
            if (i == 8) check("hold_ready_free", m_ready, 1);
            tick();
        end
        check("hold_bits", cap16, 16'h0FF0);
        check("hold_contig", vm16, 16'hFFFF);
        check("hold_idle", m_sv, 0);

        // Stall for 3 cycles with cnt=3
        w = 8'($urandom);
        load_m(w);
        for (int i = 0; i < 3; i++) begin
            cap[7 - i] = m_out;
            tick();
        end
        b = m_out;
        cap[4] = b;
        m_en = 1'b0;
        repeat (3) begin
            tick();
            check("stall_out", m_out, b);
            check("stall_valid", m_sv, 1);
            check("stall_first", m_first, 0);
            check("stall_last", m_last, 0);
        end
        m_en = 1'b1;
        tick();
        for (int i = 4; i < 8; i++) begin
            cap[7 - i] = m_out;
            tick();
        end
        check("stall_bits", cap, w);
        check("stall_idle", m_sv, 0);

        // Bypass load of 0x81 at the ser_last edge
        load_m(8'($urandom));
        repeat (7) tick();
        check("byp_last", m_last, 1);
        m_valid = 1'b1;
        m_data  = 8'h81;
        tick();
        m_valid = 1'b0;
        check("byp_first", m_first, 1);
        check("byp_out", m_out, 1);
        check("byp_valid", m_sv, 1);
        wait_idle();

        // Asynchronous reset mid-frame at cnt=4
        load_m(8'($urandom));
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", m_sv, 0);
        check("arst_out", m_out, 0);
        check("arst_first", m_first, 0);
        check("arst_last", m_last, 0);
        check("arst_ready", m_ready, 1);
        check("arst_fc", m_fc, 0);
        tick();
        reset = 1'b0;
        check("arst_no_remainder", m_sv, 0);
        load_m(8'h3C);
        for (int i = 0; i < 8; i++) begin
            cap[7 - i] = m_out;
            tick();
        end
        check("arst_3c_bits", cap, 8'h3C);

        // Randomized traffic with random stalls
        for (int i = 0; i < 800; i++) begin
            m_valid = 1'($urandom_range(0, 1));
            m_data  = 8'($urandom);
            m_en    = ($urandom_range(0, 3) != 0);
            tick();
        end
        m_valid = 1'b0;
        m_en    = 1'b1;
        wait_idle();

        // Continuous back-to-back frames until frame_count wraps
        m_valid = 1'b1;
        k = 0;
        while (m_fc != 8'hFF && k < 3000) begin
            m_data = 8'($urandom);
            tick();
            k++;
        end
        check("wrap_reach_255", (k < 3000), 1);
        while (!(m_sv && m_last) && k < 3100) begin
            m_data = 8'($urandom);
            tick();
            k++;
        end
        check("wrap_last_seen", (k < 3100), 1);
        check("wrap_pre", m_fc, 8'hFF);
        tick();
        check("wrap_post", m_fc, 8'h00);
        m_valid = 1'b0;
        wait_idle();

        // LSB-first instance: 0x01 then a random word
        l_valid = 1'b1;
        l_data  = 8'h01;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cap[i] = l_out;
            fm[i]  = l_first;
            lm[i]  = l_last;
            tick();
        end
        check("lsb_01_bits", cap, 8'h01);
        check("lsb_first", fm, 8'h01);
        check("lsb_last", lm, 8'h80);
        w = 8'($urandom);
        l_valid = 1'b1;
        l_data  = w;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cap[i] = l_out;
            tick();
        end
        check("lsb_rand_bits", cap, w);
        check("lsb_idle", l_sv, 0);
        check("lsb_fc", l_fc, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
